// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-cache initiator: cache commands,
// access sizes, FSM states and the alignment rule.
package mem_access_pkg;
  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RMWR, S_WR, S_ERR, S_DONE
  } state_t;

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) || (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge
// into the word just read from the cache.
module mau_lane_align
  import mem_access_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [1:0]    off,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] load_data,
  output logic [DW-1:0] store_word
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_data = {{(DW-8){sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{(DW-16){sign_ext & lane_h[15]}}, lane_h};
      default: load_data = rdata;
    endcase
    store_word = rdata;
    case (size)
      SZ_BYTE: store_word[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-cache initiator: one load/store at a time, waits out BUSY,
// sub-word stores done as read-modify-write against a word-only cache.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [1:0]    MEM,
  output logic [31:0]   Addr,
  output logic [31:0]   Wdata,
  input  logic [31:0]   Rdata,
  input  logic          BUSY
);
  state_t        state, state_nx;
  logic          sgn_q;
  logic [1:0]    size_q, off_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] ld_data, st_word;
  logic          accept, req_bad;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_bad   = bad_access(req_size, req_addr[1:0]);

  mau_lane_align #(.DW(DW)) u_align (
    .size      (size_q),
    .sign_ext  (sgn_q),
    .off       (off_q),
    .rdata     (Rdata),
    .wdata     (wdata_q),
    .load_data (ld_data),
    .store_word(st_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // ERR doubles as the response cycle so errors complete one cycle after accept.
  always_comb begin
    state_nx  = state;
    MEM       = MEM_IDLE;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        if (req_bad)                 state_nx = S_ERR;
        else if (!req_we)            state_nx = S_RD;
        else if (req_size == SZ_WORD) state_nx = S_WR;
        else                          state_nx = S_RMWR;
      end
      S_RD: begin
        MEM = MEM_RD;
        if (!BUSY) state_nx = S_DONE;
      end
      S_RMWR: begin
        MEM = MEM_RD;
        if (!BUSY) state_nx = S_WR;
      end
      S_WR: begin
        MEM = MEM_WR;
        if (!BUSY) state_nx = S_DONE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      Addr     <= '0;
      Wdata    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        sgn_q    <= req_signed;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        Addr     <= 32'(req_addr[AW-1:2]);
        rsp_data <= '0;
        rsp_err  <= req_bad;
        if (req_we) Wdata <= req_wdata;
      end
      if (state == S_RD && !BUSY)   rsp_data <= ld_data;
      if (state == S_RMWR && !BUSY) Wdata    <= st_word;
    end
  end
endmodule
